// File: rtl/kodon_dizi_skor_pkg.sv
// kodon_pkg
// Shared definitions for the codon sequence scoring block.
//   NUC_W     : bits per nucleotide.
//   state_e   : sequencer states (IDLE / RUN / DONE).
//   nuc_count : number of nucleotides held in a codon of a given width.
package kodon_pkg;

  localparam int NUC_W = 2;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  function automatic int nuc_count(input int kodon_w);
    return kodon_w / NUC_W;
  endfunction

endpackage

// File: rtl/kodon_dizi_skor_if.sv
// kodon_dizi_skor_if
// Control, codon-pair handshake and score result bundle of kodon_dizi_skor.
//   master : codon source / result consumer side
//   slave  : the scoring block
// Optional macro TAM_ESLESME_SAYAC_EN adds the tam_eslesme full-match count.
interface kodon_dizi_skor_if #(
  parameter int NUC_PER_CODON = 3,
  parameter int SEQ_LEN       = 8
);
  import kodon_pkg::*;

  localparam int KODON_W  = NUC_W * NUC_PER_CODON;
  localparam int SKOR_W   = $clog2(NUC_PER_CODON + 1);
  localparam int TOPLAM_W = $clog2(NUC_PER_CODON * SEQ_LEN + 1);
  localparam int IDX_W    = (SEQ_LEN > 1) ? $clog2(SEQ_LEN) : 1;

  logic                start;
  logic                iptal;
  logic                in_valid;
  logic                in_ready;
  logic [KODON_W-1:0]  kodon_a;
  logic [KODON_W-1:0]  kodon_b;
  logic [SKOR_W-1:0]   kodon_skor;
  logic                skor_valid;
  logic [TOPLAM_W-1:0] toplam_skor;
  logic                busy;
  logic                done;
`ifdef TAM_ESLESME_SAYAC_EN
  logic [IDX_W:0]      tam_eslesme;
`endif

  modport master (
`ifdef TAM_ESLESME_SAYAC_EN
    input  tam_eslesme,
`endif
    output start, iptal, in_valid, kodon_a, kodon_b,
    input  in_ready, kodon_skor, skor_valid, toplam_skor, busy, done
  );

  modport slave (
`ifdef TAM_ESLESME_SAYAC_EN
    output tam_eslesme,
`endif
    input  start, iptal, in_valid, kodon_a, kodon_b,
    output in_ready, kodon_skor, skor_valid, toplam_skor, busy, done
  );

endinterface

// File: rtl/kodon_dizi_skor_esles_say.sv
// kodon_esles_say
// Combinational match counter: number of 2-bit nucleotide fields that are
// equal between two codons.
//   kodon_a_i, kodon_b_i : codons, nucleotide k at bits [2k+1:2k]
//   skor_o               : count of equal nucleotides (0..NUC_PER_CODON)
module kodon_esles_say
  import kodon_pkg::*;
#(
  parameter  int NUC_PER_CODON = 3,
  localparam int KODON_W       = NUC_W * NUC_PER_CODON,
  localparam int SKOR_W        = $clog2(NUC_PER_CODON + 1)
) (
  input  logic [KODON_W-1:0] kodon_a_i,
  input  logic [KODON_W-1:0] kodon_b_i,
  output logic [SKOR_W-1:0]  skor_o
);

  always_comb begin
    skor_o = '0;
    for (int k = 0; k < nuc_count(KODON_W); k++) begin
      if (kodon_a_i[NUC_W*k +: NUC_W] == kodon_b_i[NUC_W*k +: NUC_W]) begin
        skor_o = skor_o + SKOR_W'(1);
      end
    end
  end

endmodule

// File: rtl/kodon_dizi_skor.sv
// kodon_dizi_skor
// Streaming codon sequence comparator. After start, accepts SEQ_LEN codon
// pairs over in_valid/in_ready, scores each pair by its equal nucleotides
// and accumulates the sequence total; done pulses with the last score.
//   clk   : clock, all logic on posedge
//   rst_n : synchronous active-low reset
//   bus   : kodon_dizi_skor_if slave (start/iptal control, pair handshake,
//           kodon_skor/skor_valid, toplam_skor, busy, done)
// Optional macro TAM_ESLESME_SAYAC_EN adds tam_eslesme, the number of pairs
// in the current sequence that matched on every nucleotide.
module kodon_dizi_skor
  import kodon_pkg::*;
#(
  parameter int NUC_PER_CODON = 3,
  parameter int SEQ_LEN       = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  kodon_dizi_skor_if.slave   bus
);

  localparam int KODON_W  = NUC_W * NUC_PER_CODON;
  localparam int SKOR_W   = $clog2(NUC_PER_CODON + 1);
  localparam int TOPLAM_W = $clog2(NUC_PER_CODON * SEQ_LEN + 1);
  localparam int IDX_W    = (SEQ_LEN > 1) ? $clog2(SEQ_LEN) : 1;

  state_e              state_q;
  logic [IDX_W-1:0]    idx_q;
  logic [SKOR_W-1:0]   kodon_skor_q;
  logic                skor_valid_q;
  logic [TOPLAM_W-1:0] toplam_q;
  logic                done_q;

  logic [SKOR_W-1:0]   skor_d;
  logic [TOPLAM_W-1:0] toplam_d;
  logic                last_d;

  kodon_esles_say #(
    .NUC_PER_CODON(NUC_PER_CODON)
  ) u_esles_say (
    .kodon_a_i(bus.kodon_a),
    .kodon_b_i(bus.kodon_b),
    .skor_o   (skor_d)
  );

  assign toplam_d = toplam_q + TOPLAM_W'(skor_d);
  assign last_d   = (idx_q == IDX_W'(SEQ_LEN - 1));

`ifdef TAM_ESLESME_SAYAC_EN
  localparam int TAM_W = IDX_W + 1;
  logic [TAM_W-1:0] tam_q;

  // Full-match counter follows the accumulator: cleared on an accepted
  // start, bumped on a transfer that matched every nucleotide.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      tam_q <= '0;
    end else if (state_q == IDLE && bus.start && !bus.iptal) begin
      tam_q <= '0;
    end else if (state_q == RUN && !bus.iptal && bus.in_valid &&
                 skor_d == SKOR_W'(NUC_PER_CODON)) begin
      tam_q <= tam_q + TAM_W'(1);
    end
  end

  assign bus.tam_eslesme = tam_q;
`endif

  // Sequencer. iptal is checked before the transfer so an aborted cycle
  // neither scores nor pulses done; the total keeps its partial value.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      idx_q        <= '0;
      kodon_skor_q <= '0;
      skor_valid_q <= 1'b0;
      toplam_q     <= '0;
      done_q       <= 1'b0;
    end else begin
      skor_valid_q <= 1'b0;
      done_q       <= 1'b0;
      case (state_q)
        IDLE: begin
          if (bus.start && !bus.iptal) begin
            state_q  <= RUN;
            idx_q    <= '0;
            toplam_q <= '0;
          end
        end
        RUN: begin
          if (bus.iptal) begin
            state_q <= IDLE;
          end else if (bus.in_valid) begin
            kodon_skor_q <= skor_d;
            skor_valid_q <= 1'b1;
            toplam_q     <= toplam_d;
            if (last_d) begin
              state_q <= DONE;
              done_q  <= 1'b1;
            end else begin
              idx_q <= idx_q + IDX_W'(1);
            end
          end
        end
        DONE: begin
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign bus.in_ready    = (state_q == RUN);
  assign bus.busy        = (state_q == RUN);
  assign bus.kodon_skor  = kodon_skor_q;
  assign bus.skor_valid  = skor_valid_q;
  assign bus.toplam_skor = toplam_q;
  assign bus.done        = done_q;

endmodule
